// File: rtl/prefetch_queue_controller.sv
// prefetch_queue_controller: BIU sequencer filling the 6-byte prefetch FIFO over a shared 16-bit bus
module prefetch_queue_controller #(
    parameter int DEPTH = 6,
    parameter int WIDTH_COUNT = 3,
    parameter int WIDTH_ADDRESS = 20,
    parameter logic [WIDTH_ADDRESS-1:0] RESET_ADDRESS = 20'hFFFF0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH_COUNT-1:0]   fifo_count,
    output logic                     fifo_write_enable,
    output logic [7:0]               fifo_write_data,
    output logic                     fifo_clear,
    input  logic                     flush,
    input  logic [WIDTH_ADDRESS-1:0] flush_address,
    input  logic                     eu_bus_request,
    output logic                     eu_bus_grant,
    output logic                     bus_request,
    output logic [WIDTH_ADDRESS-1:0] bus_address,
    input  logic                     bus_ready,
    input  logic [15:0]              bus_read_data,
    output logic [WIDTH_ADDRESS-1:0] fetch_address
);
    typedef enum logic [2:0] {IDLE, FETCH, PUSH_LO, PUSH_HI, EU_OWN} state_t;
    state_t state_q, state_d;
    logic [WIDTH_ADDRESS-1:0] ptr_q, ptr_d, bus_address_q, bus_address_d;
    logic [15:0] word_q, word_d;
    logic [7:0] fifo_write_data_q, fifo_write_data_d;
    logic fifo_write_enable_q, fifo_write_enable_d;
    logic fifo_clear_q, fifo_clear_d;
    logic eu_bus_grant_q, eu_bus_grant_d;
    logic bus_request_q, bus_request_d;
    logic can_fetch;
    // an odd pointer only consumes the high byte of its word
    assign can_fetch = int'(fifo_count) + (ptr_q[0] ? 1 : 2) <= DEPTH;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        word_d = word_q;
        case (state_q)
            IDLE:    state_d = eu_bus_request ? EU_OWN : can_fetch ? FETCH : IDLE;
            FETCH: begin
                if (bus_ready) begin
                    word_d = bus_read_data;
                    state_d = ptr_q[0] ? PUSH_HI : PUSH_LO;
                end
            end
            PUSH_LO: begin
                ptr_d = ptr_q + WIDTH_ADDRESS'(1);
                state_d = PUSH_HI;
            end
            PUSH_HI: begin
                ptr_d = ptr_q + WIDTH_ADDRESS'(1);
                state_d = IDLE;
            end
            EU_OWN:  state_d = eu_bus_request ? EU_OWN : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            ptr_d = flush_address;
            state_d = state_q == EU_OWN ? EU_OWN : IDLE;
        end
        fifo_write_enable_d = state_d == PUSH_LO || state_d == PUSH_HI;
        fifo_write_data_d = state_d == PUSH_LO ? word_d[7:0] : state_d == PUSH_HI ? word_d[15:8] : 8'h00;
        fifo_clear_d = flush;
        eu_bus_grant_d = state_d == EU_OWN;
        bus_request_d = state_d == FETCH;
        bus_address_d = bus_request_d ? {ptr_d[WIDTH_ADDRESS-1:1], 1'b0} : '0;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q <= RESET_ADDRESS;
            word_q <= '0;
            fifo_write_enable_q <= 1'b0;
            fifo_write_data_q <= '0;
            fifo_clear_q <= 1'b0;
            eu_bus_grant_q <= 1'b0;
            bus_request_q <= 1'b0;
            bus_address_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            word_q <= word_d;
            fifo_write_enable_q <= fifo_write_enable_d;
            fifo_write_data_q <= fifo_write_data_d;
            fifo_clear_q <= fifo_clear_d;
            eu_bus_grant_q <= eu_bus_grant_d;
            bus_request_q <= bus_request_d;
            bus_address_q <= bus_address_d;
        end
    end
    assign fifo_write_enable = fifo_write_enable_q;
    assign fifo_write_data = fifo_write_data_q;
    assign fifo_clear = fifo_clear_q;
    assign eu_bus_grant = eu_bus_grant_q;
    assign bus_request = bus_request_q;
    assign bus_address = bus_address_q;
    assign fetch_address = ptr_q;
endmodule

// File: tb/tb_prefetch_queue_controller.sv
// tb_prefetch_queue_controller: directed vector table plus randomized run against a FIFO/memory model
module tb_prefetch_queue_controller;
    localparam int DEPTH = 6;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [2:0] fifo_count = '0;
    logic fifo_write_enable, fifo_clear, eu_bus_grant, bus_request;
    logic [7:0] fifo_write_data;
    logic flush = 1'b0;
    logic [19:0] flush_address = '0;
    logic eu_bus_request = 1'b0;
    logic [19:0] bus_address, fetch_address;
    logic bus_ready = 1'b0;
    logic [15:0] bus_read_data = '0;

    always #5 clock = ~clock;

    prefetch_queue_controller dut (
        .clock(clock), .reset(reset), .fifo_count(fifo_count),
        .fifo_write_enable(fifo_write_enable), .fifo_write_data(fifo_write_data),
        .fifo_clear(fifo_clear), .flush(flush), .flush_address(flush_address),
        .eu_bus_request(eu_bus_request), .eu_bus_grant(eu_bus_grant),
        .bus_request(bus_request), .bus_address(bus_address), .bus_ready(bus_ready),
        .bus_read_data(bus_read_data), .fetch_address(fetch_address)
    );

    typedef struct {
        logic rst_n; logic [2:0] cnt; logic fl; logic [19:0] fad; logic eu; logic rdy; logic [15:0] rd;
        logic we; logic [7:0] wd; logic clr; logic gnt; logic req; logic [19:0] ba; logic [19:0] fa;
    } vec_t;
    vec_t vecs[$];
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] c, input logic f, input logic [19:0] fad,
                       input logic e, input logic rdy, input logic [15:0] d, input logic we,
                       input logic [7:0] wd, input logic clr, input logic g, input logic rq,
                       input logic [19:0] ba, input logic [19:0] fa);
        vec_t v;
        v.rst_n = r; v.cnt = c; v.fl = f; v.fad = fad; v.eu = e; v.rdy = rdy; v.rd = d;
        v.we = we; v.wd = wd; v.clr = clr; v.gnt = g; v.req = rq; v.ba = ba; v.fa = fa;
        vecs.push_back(v);
    endtask

    // memory contents seen by the bus: an arbitrary but fixed byte per address
    function automatic logic [7:0] mem_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'hC3;
    endfunction

    logic [7:0] q[$];
    logic [19:0] exp_ptr;
    logic flush_prev, eu_prev;
    int wait_cnt, n_push, cnt_now;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //   rst cnt fl fad       eu rdy data     | we wd    clr gnt req ba        fa
        add(0, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'hFFFF0);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'hFFFF0, 20'hFFFF0);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'hFFFF0, 20'hFFFF0);
        add(1, 0, 0, 20'h0,     0, 1, 16'hB0EA, 1, 8'hEA, 0, 0, 0, 20'h0,     20'hFFFF0);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    1, 8'hB0, 0, 0, 0, 20'h0,     20'hFFFF1);
        add(1, 2, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'hFFFF2);
        add(1, 5, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'hFFFF2);
        add(1, 5, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'hFFFF2);
        add(1, 4, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'hFFFF2, 20'hFFFF2);
        add(1, 4, 1, 20'h00101, 0, 1, 16'h1234, 0, 8'h00, 1, 0, 0, 20'h0,     20'h00101);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'h00100, 20'h00101);
        add(1, 0, 0, 20'h0,     0, 1, 16'h7733, 1, 8'h77, 0, 0, 0, 20'h0,     20'h00101);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'h00102);
        add(1, 1, 0, 20'h0,     1, 0, 16'h0,    0, 8'h00, 0, 1, 0, 20'h0,     20'h00102);
        add(1, 1, 0, 20'h0,     1, 0, 16'h0,    0, 8'h00, 0, 1, 0, 20'h0,     20'h00102);
        add(1, 1, 1, 20'hFFFFF, 1, 0, 16'h0,    0, 8'h00, 1, 1, 0, 20'h0,     20'hFFFFF);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'hFFFFF);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'hFFFFE, 20'hFFFFF);
        add(1, 0, 0, 20'h0,     0, 1, 16'hC4D5, 1, 8'hC4, 0, 0, 0, 20'h0,     20'hFFFFF);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'h00000);
        add(1, 1, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'h00000, 20'h00000);
        add(1, 1, 0, 20'h0,     1, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'h00000, 20'h00000);
        add(1, 1, 0, 20'h0,     1, 1, 16'h2211, 1, 8'h11, 0, 0, 0, 20'h0,     20'h00000);
        add(1, 1, 0, 20'h0,     1, 0, 16'h0,    1, 8'h22, 0, 0, 0, 20'h0,     20'h00001);
        add(1, 1, 0, 20'h0,     1, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'h00002);
        add(1, 3, 0, 20'h0,     1, 0, 16'h0,    0, 8'h00, 0, 1, 0, 20'h0,     20'h00002);
        add(1, 3, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'h00002);
        add(1, 3, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'h00002, 20'h00002);
        add(1, 3, 0, 20'h0,     0, 1, 16'h4433, 1, 8'h33, 0, 0, 0, 20'h0,     20'h00002);
        add(1, 3, 1, 20'h12345, 0, 0, 16'h0,    0, 8'h00, 1, 0, 0, 20'h0,     20'h12345);
        add(1, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 1, 20'h12344, 20'h12345);
        add(0, 0, 0, 20'h0,     0, 0, 16'h0,    0, 8'h00, 0, 0, 0, 20'h0,     20'hFFFF0);
        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst_n; fifo_count = vecs[i].cnt; flush = vecs[i].fl;
            flush_address = vecs[i].fad; eu_bus_request = vecs[i].eu;
            bus_ready = vecs[i].rdy; bus_read_data = vecs[i].rd;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d", i),
                64'({fifo_write_enable, fifo_write_data, fifo_clear, eu_bus_grant, bus_request, bus_address, fetch_address}),
                64'({vecs[i].we, vecs[i].wd, vecs[i].clr, vecs[i].gnt, vecs[i].req, vecs[i].ba, vecs[i].fa}));
        end
        @(negedge clock);
        reset = 1'b0; flush = 1'b0; eu_bus_request = 1'b0; bus_ready = 1'b0; fifo_count = '0;
        @(negedge clock);
        reset = 1'b1;
        exp_ptr = 20'hFFFF0; flush_prev = 1'b0; eu_prev = 1'b0; wait_cnt = 0; n_push = 0;
        q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            cnt_now = q.size();
            chk("fetch_address", 64'(fetch_address), 64'(exp_ptr));
            chk("clear_pulse", 64'(fifo_clear), 64'(flush_prev));
            if (flush_prev) chk("flush_abort", 64'({fifo_write_enable, bus_request}), 64'(0));
            if (fifo_write_enable) begin
                chk("not_full", 64'(q.size() < DEPTH), 64'(1));
                chk("push_byte", 64'(fifo_write_data), 64'(mem_byte(exp_ptr)));
            end
            if (bus_request) chk("bus_address", 64'(bus_address), 64'({exp_ptr[19:1], 1'b0}));
            if (eu_bus_grant && !flush_prev) chk("grant_owner", 64'({eu_prev, bus_request}), 64'(2'b10));
            wait_cnt = (eu_bus_request && !eu_bus_grant) ? wait_cnt + 1 : 0;
            if (eu_bus_request) begin
                chk("eu_wait_bound", 64'(wait_cnt > 200), 64'(0));
                if (wait_cnt > 200) wait_cnt = 0;
            end
            if (fifo_clear) q.delete();
            if (q.size() > 0 && $urandom_range(0, 2) == 0) void'(q.pop_front());
            if (fifo_write_enable) begin
                q.push_back(fifo_write_data);
                exp_ptr = exp_ptr + 20'd1;
                n_push++;
            end
            fifo_count = 3'(cnt_now);
            flush = !flush_prev && $urandom_range(0, 39) == 0;
            if (flush) begin
                flush_address = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
                exp_ptr = flush_address;
            end
            flush_prev = flush;
            if (!eu_bus_request) eu_bus_request = $urandom_range(0, 29) == 0;
            else if (eu_bus_grant) eu_bus_request = $urandom_range(0, 3) != 0;
            eu_prev = eu_bus_request;
            bus_ready = bus_request && $urandom_range(0, 2) == 0;
            bus_read_data = bus_ready ? {mem_byte({bus_address[19:1], 1'b1}), mem_byte({bus_address[19:1], 1'b0})}
                                      : 16'($urandom);
        end
        chk("bytes_pushed", 64'(n_push > 100), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
